core_sequencer: RTL
===================

Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the single-issue RV32 core through FETCH, DECODE, EXECUTE, MEM and WB.
- Owns the PC and the instruction register, and feeds the instruction decoder/regfile block.
- Arbitrates the instruction and data memory request/ack handshakes.
- Selects the writeback source and pulses the regfile write enable exactly once per retired instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc_out)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
pc_out  out  32  current PC to decoder
inst_out  out  32  latched instruction register to decoder
dec_rd  in  5  decoder rd_out
dec_rd_wen  in  1  decoder rd_wen
dec_mem_re  in  1  decoder mem_re
dec_mem_we  in  1  decoder mem_we
dec_wb_sel  in  3  decoder wb_sel, one-hot {MEM,PC,CSR}
dec_rs2_data  in  32  store data from regfile
alu_out  in  32  ALU result (address for load/store)
branch_taken  in  1  redirect request, sampled in EXECUTE
branch_target  in  32  redirect PC
csr_rdata  in  32  CSR read data
dmem_req  out  1  data memory request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  32  data address
dmem_wdata  out  32  store data
dmem_ack  in  1  data access complete; dmem_rdata valid for loads
dmem_rdata  in  32  load data
wb_we  out  1  regfile write enable (one-cycle pulse)
wb_addr  out  5  regfile write address
wb_data  out  32  regfile write data
retire  out  1  one-cycle pulse per completed instruction
state_out  out  3  current state, debug

Behaviour:
- Reset (rst_n=0 at a clk edge) puts the block in the following state:
  - state=FETCH, pc=RESET_PC, IR=32'h0000_0013 (NOP).
  - All latched controls and data cleared.
  - All req/we/retire outputs are 0 during and on the cycle after reset.
  - Reset mid-transaction drops any outstanding req immediately; a late ack is ignored.
- State encoding, shared package: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On imem_ack=1 (may arrive in the first req cycle), IR<=imem_rdata and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - One cycle; decoder outputs settle from inst_out/pc_out.
  - Latch rd, rd_wen, mem_re, mem_we, wb_sel and rs2_data. Go to EXECUTE.
- EXECUTE:
  - One cycle; latch alu_out into alu_q.
  - Compute npc: branch_target with bits[1:0] forced 0 if branch_taken, else pc+4 (mod 2^32, wraps).
  - If mem_re or mem_we, go to MEM; else go to WB.
- MEM:
  - dmem_req=1, dmem_addr=alu_q, dmem_we=mem_we_q, dmem_wdata=rs2_q, all held stable until dmem_ack.
  - mem_we takes priority if both mem_re and mem_we are set.
  - On dmem_ack, latch dmem_rdata into ld_q and go to WB.
- WB:
  - One cycle; wb_we=rd_wen_q, wb_addr=rd_q, retire=1, pc<=npc. Go to FETCH.
  - wb_data priority: MEM→ld_q, PC→pc+4 of the retiring instruction, CSR→csr_rdata, none→alu_q.
  - rd=0 is still forwarded; the regfile ignores x0 writes.
- Acks arriving outside their own request state are ignored.
- imem_req and dmem_req are never asserted in the same cycle.
- Latency with zero-wait ack: ALU op = 4 cycles, load/store = 5 cycles. Each wait cycle adds 1.
- No watchdog: a missing ack stalls the FSM indefinitely.

Decomposition:
- Package core_pkg holds:
  - state enum/localparams;
  - WB_SEL bit indices (MEM=2, PC=1, CSR=0);
  - NOP constant 32'h0000_0013;
  - RESET_PC default.
- One natural sub-module: wb_mux, the combinational writeback-source select, kept separate so it can be reused by a later pipelined core.
- The FSM, PC and latches stay in core_sequencer.

Test Plan:
1. Reset release with imem_ack tied 1, IR=ADDI x1:
   - imem_addr=0 on the first cycle.
   - wb_we and retire pulse on cycle 4.
   - Second fetch at imem_addr=4 on cycle 5.
2. Load, dec_mem_re=1, alu_out=0x100, dmem_ack delayed 3 cycles, dmem_rdata=0xDEADBEEF:
   - dmem_req held with addr 0x100 for 4 cycles.
   - wb_data=0xDEADBEEF, wb_we=1.
   - Total 8 cycles.
3. Store, dec_mem_we=1, rs2=0x12345678:
   - dmem_we=1 and dmem_wdata=0x12345678.
   - wb_we=0, retire=1.
4. Branch: branch_taken=1, branch_target=0x203 in EXECUTE:
   - Next imem_addr=0x200.
   - pc=0xFFFFFFFC without branch → next fetch at 0x0.
5. rst_n=0 during a MEM wait:
   - dmem_req=0 next cycle, then fetch resumes at RESET_PC.
   - A subsequent dmem_ack pulse is ignored: no wb_we, no retire.
6. wb_sel=PC at pc=0x40:
   - wb_data=0x44.
   - wb_sel=CSR with csr_rdata=0xA5 → wb_data=0xA5.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle RV32 core: FSM states, writeback-select bits, reset constants.
// No logic here; imported by the sequencer and its writeback mux.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
    } state_t;

    localparam int WB_SEL_MEM = 2;
    localparam int WB_SEL_PC  = 1;
    localparam int WB_SEL_CSR = 0;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/core_wb_mux.sv
// Writeback source select: MEM > PC+4 > CSR > ALU, purely combinational.
// Zero latency, no handshake; caller qualifies the result with its write enable.
module wb_mux import core_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      wb_sel,
    input  logic [XLEN-1:0] ld_data,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] csr_data,
    input  logic [XLEN-1:0] alu_data,
    output logic [XLEN-1:0] wb_data
);

    always_comb begin
        wb_data = alu_data;
        if (wb_sel[WB_SEL_MEM])
            wb_data = ld_data;
        else if (wb_sel[WB_SEL_PC])
            wb_data = pc_plus4;
        else if (wb_sel[WB_SEL_CSR])
            wb_data = csr_data;
    end

endmodule

// File: rtl/core_sequencer.sv
// FETCH/DECODE/EXECUTE/MEM/WB control FSM owning PC and IR; 4 cycles per ALU op, 5 per load/store.
// Each memory wait cycle adds one; a missing ack stalls forever, requests are held stable until ack.
module core_sequencer import core_pkg::*; #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out,
    input  logic [4:0]      dec_rd,
    input  logic            dec_rd_wen,
    input  logic            dec_mem_re,
    input  logic            dec_mem_we,
    input  logic [2:0]      dec_wb_sel,
    input  logic [XLEN-1:0] dec_rs2_data,
    input  logic [XLEN-1:0] alu_out,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            retire,
    output logic [2:0]      state_out
);

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd_q;
    logic            rd_wen_q;
    logic            mem_re_q;
    logic            mem_we_q;
    logic [2:0]      wb_sel_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] ld_q;

    assign pc_plus4 = pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:   if (imem_ack) state_nxt = ST_DECODE;
            ST_DECODE:  state_nxt = ST_EXECUTE;
            ST_EXECUTE: state_nxt = (mem_re_q || mem_we_q) ? ST_MEM : ST_WB;
            ST_MEM:     if (dmem_ack) state_nxt = ST_WB;
            ST_WB:      state_nxt = ST_FETCH;
            default:    state_nxt = ST_FETCH;
        endcase
    end

    // Strobes are gated by rst_n so an in-flight request drops in the reset cycle itself.
    always_comb begin
        imem_req = rst_n && (state == ST_FETCH);
        dmem_req = rst_n && (state == ST_MEM);
        dmem_we  = dmem_req && mem_we_q;
        retire   = rst_n && (state == ST_WB);
        wb_we    = retire && rd_wen_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            ir       <= XLEN'(NOP_INST);
            npc      <= '0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            wb_sel_q <= '0;
            rs2_q    <= '0;
            alu_q    <= '0;
            ld_q     <= '0;
        end else begin
            case (state)
                ST_FETCH: if (imem_ack) ir <= imem_rdata;
                ST_DECODE: begin
                    rd_q     <= dec_rd;
                    rd_wen_q <= dec_rd_wen;
                    mem_re_q <= dec_mem_re;
                    mem_we_q <= dec_mem_we;
                    wb_sel_q <= dec_wb_sel;
                    rs2_q    <= dec_rs2_data;
                end
                ST_EXECUTE: begin
                    alu_q <= alu_out;
                    npc   <= branch_taken ? {branch_target[XLEN-1:2], 2'b00} : pc_plus4;
                end
                ST_MEM: if (dmem_ack) ld_q <= dmem_rdata;
                ST_WB:  pc <= npc;
                default: ;
            endcase
        end
    end

    wb_mux #(.XLEN(XLEN)) u_wb_mux (
        .wb_sel   (wb_sel_q),
        .ld_data  (ld_q),
        .pc_plus4 (pc_plus4),
        .csr_data (csr_rdata),
        .alu_data (alu_q),
        .wb_data  (wb_data)
    );

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign inst_out   = ir;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = rs2_q;
    assign wb_addr    = rd_q;
    assign state_out  = state;

endmodule
